// File: rtl/ram_arbiter_if.sv
// Bundle of requester handshakes, read result and RAM pins shared by the arbiter.
// The arbiter takes the slave view; requesters and the RAM model take the master view.
interface ram_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_ack;
  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic [ADDR_W-1:0] address;
  logic              writeOn;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  data_out,
    output a_ack, b_ack, rdata, busy, address, writeOn, data_in
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output data_out,
    input  a_ack, b_ack, rdata, busy, address, writeOn, data_in
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one asynchronous RAM between two requesters,
// sequencing each access as IDLE -> SETUP -> STROBE -> RELEASE with registered pins.
module ram_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;

  state_t            state_q;
  logic              last_b_q;
  logic              gnt_b_q;
  logic              we_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] data_in_q;
  logic [DATA_W-1:0] rdata_q;
  logic              writeOn_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic              busy_q;

  logic              take_b_d;

  // B wins only when A is absent, or on a tie when A was served last.
  always_comb begin
    take_b_d = bus.b_req & (~bus.a_req | ~last_b_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      gnt_b_q   <= 1'b0;
      we_q      <= 1'b0;
      address_q <= '0;
      data_in_q <= '0;
      rdata_q   <= '0;
      writeOn_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.a_req || bus.b_req) begin
            gnt_b_q   <= take_b_d;
            last_b_q  <= take_b_d;
            we_q      <= take_b_d ? bus.b_we    : bus.a_we;
            address_q <= take_b_d ? bus.b_addr  : bus.a_addr;
            data_in_q <= take_b_d ? bus.b_wdata : bus.a_wdata;
            busy_q    <= 1'b1;
            state_q   <= SETUP;
          end
        end
        SETUP: begin
          writeOn_q <= we_q;
          state_q   <= STROBE;
        end
        STROBE: begin
          // Address and data stay put through this edge, so the RAM write completes cleanly.
          writeOn_q <= 1'b0;
          if (!we_q) rdata_q <= bus.data_out;
          a_ack_q   <= ~gnt_b_q;
          b_ack_q   <= gnt_b_q;
          state_q   <= RELEASE;
        end
        RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.a_ack   = a_ack_q;
  assign bus.b_ack   = b_ack_q;
  assign bus.rdata   = rdata_q;
  assign bus.busy    = busy_q;
  assign bus.address = address_q;
  assign bus.writeOn = writeOn_q;
  assign bus.data_in = data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural asynchronous RAM on its pins.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n;

  ram_arbiter_if bus ();

  ram_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [32];

  assign bus.data_out = mem[bus.address];

  always @(posedge clk) begin
    if (bus.writeOn) mem[bus.address] <= bus.data_in;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One isolated transaction from a single requester, checked cycle by cycle.
  task automatic txn(input bit sel_b, input bit we, input logic [4:0] addr,
                     input logic [31:0] wd, input logic [31:0] exp_rd);
    if (sel_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    chk("txn_idle_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("txn_setup_busy", {31'd0, bus.busy}, 32'd1);
    chk("txn_setup_wr", {31'd0, bus.writeOn}, 32'd0);
    chk("txn_setup_addr", {27'd0, bus.address}, {27'd0, addr});
    chk("txn_setup_din", bus.data_in, wd);
    step();
    chk("txn_strobe_wr", {31'd0, bus.writeOn}, {31'd0, we});
    chk("txn_strobe_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("txn_strobe_addr", {27'd0, bus.address}, {27'd0, addr});
    step();
    chk("txn_rel_wr", {31'd0, bus.writeOn}, 32'd0);
    chk("txn_rel_acks", {30'd0, bus.a_ack, bus.b_ack}, sel_b ? 32'd1 : 32'd2);
    chk("txn_rel_busy", {31'd0, bus.busy}, 32'd1);
    if (!we) chk("txn_rdata", bus.rdata, exp_rd);
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    step();
    chk("txn_end_busy", {31'd0, bus.busy}, 32'd0);
    chk("txn_end_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("txn_end_wr", {31'd0, bus.writeOn}, 32'd0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    step();
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wr", {31'd0, bus.writeOn}, 32'd0);
    chk("rst_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("rst_addr", {27'd0, bus.address}, 32'd0);
    chk("rst_din", bus.data_in, 32'd0);
    chk("rst_rdata", bus.rdata, 32'd0);
    rst = 1'b0;
    step();

    // Both request from reset: A wins the first tie, B follows.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd0;  bus.a_wdata = 32'h1111_1111;
    bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 5'd31; bus.b_wdata = 32'h2222_2222;
    step();
    chk("tie_first_addr", {27'd0, bus.address}, 32'd0);
    step();
    step();
    chk("tie_a_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd2);
    bus.a_req = 1'b0;
    step();
    chk("tie_gap_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    chk("tie_gap_busy", {31'd0, bus.busy}, 32'd0);
    step();
    chk("tie_second_addr", {27'd0, bus.address}, 32'd31);
    chk("tie_second_din", bus.data_in, 32'h2222_2222);
    step();
    step();
    chk("tie_b_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd1);
    bus.b_req = 1'b0;
    step();

    txn(1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'd0);
    chk("mem3", mem[3], 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 5'd3, 32'd0, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 5'd0, 32'd0, 32'h1111_1111);
    txn(1'b1, 1'b0, 5'd31, 32'd0, 32'h2222_2222);

    // Continuous requests from both sides: alternating grants, acks 4 cycles apart.
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 5'd0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 5'd31;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!(bus.a_ack || bus.b_ack) && n < 10);
      chk("rr_order", {31'd0, bus.b_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_excl", {31'd0, bus.a_ack & bus.b_ack}, 32'd0);
      chk("rr_gap", n, (i == 0) ? 32'd3 : 32'd4);
      chk("rr_rdata", bus.rdata, (i % 2 == 1) ? 32'h2222_2222 : 32'h1111_1111);
      if (i == 7) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
    end
    step();

    // Reset asserted during the strobe of a write.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd7; bus.a_wdata = 32'h7777_7777;
    step();
    step();
    chk("mid_strobe_wr", {31'd0, bus.writeOn}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_wr", {31'd0, bus.writeOn}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_rdata", bus.rdata, 32'd0);
    chk("mid_rst_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    bus.a_req = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_hold_acks", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
    #1;
    rst = 1'b0;
    txn(1'b0, 1'b0, 5'd0, 32'd0, 32'h1111_1111);

    // Requester fields change after acceptance; the RAM keeps the latched address.
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 5'd5; bus.a_wdata = 32'h5555_5555;
    step();
    bus.a_addr = 5'd9; bus.a_wdata = 32'h9999_9999;
    chk("hold_setup_addr", {27'd0, bus.address}, 32'd5);
    step();
    chk("hold_strobe_addr", {27'd0, bus.address}, 32'd5);
    chk("hold_strobe_din", bus.data_in, 32'h5555_5555);
    step();
    chk("hold_rel_addr", {27'd0, bus.address}, 32'd5);
    chk("hold_rel_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd2);
    bus.a_req = 1'b0;
    step();
    chk("hold_idle_addr", {27'd0, bus.address}, 32'd5);
    chk("hold_idle_wr", {31'd0, bus.writeOn}, 32'd0);
    chk("hold_mem5", mem[5], 32'h5555_5555);
    txn(1'b1, 1'b0, 5'd5, 32'd0, 32'h5555_5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester controller that sequences and shares the single asynchronous RAM (ram_async: 5-bit address, 32-bit data, level-sensitive writeOn, combinational data_out).
- Arbitrates round-robin between requester A and requester B, then drives the RAM pins with a setup/strobe/release sequence so address and data are stable whenever writeOn is high.
- Captures read data and returns a one-cycle ack to the winning requester.

Parameters:
- ADDR_W, 5, RAM address width.
- DATA_W, 32, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A transaction request; held until a_ack.
- a_we  in  1  A: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  ADDR_W  A target address.
- a_wdata  in  DATA_W  A write data.
- a_ack  out  1  one-cycle completion pulse to A.
- b_req, b_we, b_addr, b_wdata  in  1/1/ADDR_W/DATA_W  same as A, for requester B.
- b_ack  out  1  one-cycle completion pulse to B.
- rdata  out  DATA_W  read result; valid in the ack cycle and held until the next read capture.
- busy  out  1  high in every state except IDLE.
- address  out  ADDR_W  to RAM address.
- writeOn  out  1  to RAM write enable.
- data_in  out  DATA_W  to RAM data_in.
- data_out  in  DATA_W  from RAM data_out.

Behaviour:
- Reset values: a_ack = b_ack = 0, writeOn = 0, busy = 0, address = 0, data_in = 0, rdata = 0, state = IDLE, last_grant = B (A wins the first tie).
- FSM states: IDLE, SETUP, STROBE, RELEASE. Every transaction takes exactly 4 cycles.
- IDLE:
  - If any req is high, pick the winner and latch its we, addr and wdata into internal registers, then go to SETUP.
  - If both reqs are high, grant the requester other than last_grant. Update last_grant to the winner.
  - If only one req is high, grant it regardless of last_grant.
- SETUP: address and data_in driven from the latched values; writeOn = 0.
- STROBE:
  - writeOn = latched we. Address and data_in are unchanged.
  - For a read, rdata <= data_out on the clock edge that leaves STROBE.
  - For a write, rdata is unchanged.
- RELEASE:
  - writeOn = 0; address and data_in still held.
  - The winner's ack = 1 for this cycle only. Next state is IDLE.
- Latency: the request is accepted at IDLE edge 0, and ack is high during the 4th cycle (RELEASE).
- writeOn must never be high in the same cycle that address or data_in changes. It is registered, glitch-free and high only in STROBE.
- Requester rule: at the edge where ack is seen, deassert req or present a new request. A req still high in the following IDLE cycle is treated as a new transaction.
- Requester fields are sampled only in IDLE. Changes after acceptance do not affect the transaction in flight.
- Starvation bound: with both requesters continuously requesting, grants alternate A, B, A, B; each requester waits at most 8 cycles.
- Only one ack is high in any cycle; acks are never both high.
- Address wrap: no arithmetic. Addresses 0 and 31 are passed through unchanged.
- Reset mid-transaction:
  - writeOn, acks and busy drop asynchronously and the state returns to IDLE.
  - No ack is issued; the in-flight write may or may not have completed, and the requester must reissue it.
  - rdata returns to 0.
- Idle with no requests: outputs hold their last address and data_in values, writeOn = 0.

Test Plan:
- Reset, then A writes 0xDEADBEEF to address 3 → writeOn high for exactly 1 cycle (cycle 3 after acceptance) with address = 3; a_ack pulses on cycle 4; busy high for 3 cycles.
- A reads address 3 after that write → a_ack on cycle 4 with rdata = 0xDEADBEEF; writeOn stays 0 throughout.
- A and B both request from reset (A writes 0x11111111 to addr 0, B writes 0x22222222 to addr 31) and both hold req → A served first, B second. Readback gives addr 0 = 0x11111111, addr 31 = 0x22222222; acks never overlap.
- Both requesters request continuously for 4 transactions each → grant order A, B, A, B, A, B, A, B; consecutive acks are 4 cycles apart.
- Assert rst during STROBE of a write to addr 7 → writeOn = 0 and state = IDLE immediately; no a_ack; next request is accepted normally 1 cycle after rst falls.
- Change a_addr from 5 to 9 during SETUP → the RAM address stays 5 until RELEASE completes.
